// File: rtl/bit_serial_pkg.sv
// Shared types and helpers for the bit-serial adder.
// Optional subtract mode is controlled by the SERIAL_ADDER_SUB_EN macro (see top level).
package bit_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width of the bit counter that walks 0 .. WIDTH-1.
  function automatic int CNT_W(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder with its carry flip-flop.
// The carry is preset on load (0 for add, 1 for subtract) and
// advances to the majority of a, b and carry on every enabled cycle.
module serial_fa_cell (
  input  logic CLK,
  input  logic reset_n,
  input  logic a,
  input  logic b,
  input  logic carry_preset,
  input  logic load,
  input  logic enable,
  output logic s,
  output logic carry
);

  logic r_carry;

  assign s     = a ^ b ^ r_carry;
  assign carry = r_carry;

  // Carry register: preset on load, majority update while shifting.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_carry <= 1'b0;
    end else if (load) begin
      r_carry <= carry_preset;
    end else if (enable) begin
      r_carry <= (a & b) | (a & r_carry) | (b & r_carry);
    end
  end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands LSB-first, one bit per clock,
// through a single full-adder cell, with a start/busy/done handshake.
// Optional feature macro: SERIAL_ADDER_SUB_EN enables the subtract mode
// (b loaded with ~y and carry preset to 1 when sub=1).
//
// Handshake: start is sampled only in IDLE; the operands and sub are captured
// on that edge. busy is high while bits are being shifted. done is a one-cycle
// pulse coinciding with the update of sum, which then holds until the next done.
// dbg_state exposes the FSM state for observation.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum,
  output state_t           dbg_state
);

  localparam int            CW   = CNT_W(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_p;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_sum;
  logic             r_done;
  logic             r_busy;

  logic             w_load;
  logic             w_shift;
  logic [WIDTH-1:0] w_b_load;
  logic             w_preset;
  logic             w_s;
  logic             w_carry;

  assign w_load  = (r_state == IDLE) && start;
  assign w_shift = (r_state == SHIFT);

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract as x + ~y + 1: invert b and preset the carry.
  assign w_b_load = sub ? ~y : y;
  assign w_preset = sub;
`else
  // Add-only build: sub has no effect.
  logic w_unused_sub;
  assign w_unused_sub = sub;
  assign w_b_load     = y;
  assign w_preset     = 1'b0;
`endif

  serial_fa_cell u_fa (
    .CLK          (CLK),
    .reset_n      (reset_n),
    .a            (r_a[0]),
    .b            (r_b[0]),
    .carry_preset (w_preset),
    .load         (w_load),
    .enable       (w_shift),
    .s            (w_s),
    .carry        (w_carry)
  );

  // Sequencer FSM with operand/result shift registers and registered outputs.
  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_p     <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= x;
            r_b     <= w_b_load;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a   <= {1'b0, r_a[WIDTH-1:1]};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_p   <= {w_s, r_p[WIDTH-1:1]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_busy  <= 1'b0;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_sum   <= {w_carry, r_p};
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign dbg_state = r_state;

endmodule
